// File: rtl/axi_aw_rr_scheduler_if.sv
// Write-address bundle between N requesting AW ports, the single downstream AW channel
// and the write-data allocator ID FIFO.
interface axi_aw_rr_scheduler_if #(
   parameter int N_TARG_PORT = 7,
   parameter int PAYLOAD_W   = 64,
   parameter int LOG_N_TARG  = $clog2(N_TARG_PORT)
);
   logic [N_TARG_PORT-1:0]                awvalid_i;
   logic [N_TARG_PORT-1:0][PAYLOAD_W-1:0] awpayload_i;
   logic [N_TARG_PORT-1:0]                awready_o;
   logic                                  awvalid_o;
   logic [PAYLOAD_W-1:0]                  awpayload_o;
   logic                                  awready_i;
   logic                                  push_ID_o;
   logic [LOG_N_TARG+N_TARG_PORT-1:0]     ID_o;
   logic                                  grant_FIFO_ID_i;

   // The scheduler itself
   modport slave (
      input  awvalid_i, awpayload_i, awready_i, grant_FIFO_ID_i,
      output awready_o, awvalid_o, awpayload_o, push_ID_o, ID_o
   );

   // Requesters, downstream slave and ID FIFO as seen from outside
   modport master (
      output awvalid_i, awpayload_i, awready_i, grant_FIFO_ID_i,
      input  awready_o, awvalid_o, awpayload_o, push_ID_o, ID_o
   );
endinterface

// File: rtl/axi_aw_rr_scheduler.sv
// Round-robin AW arbiter with a single output slot; every grant pushes the winner's
// routing ID into the write-data allocator FIFO in the same cycle.
module axi_aw_rr_scheduler #(
   parameter int N_TARG_PORT = 7,
   parameter int PAYLOAD_W   = 64,
   parameter int LOG_N_TARG  = $clog2(N_TARG_PORT)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   axi_aw_rr_scheduler_if.slave   bus
);
   localparam int LW = LOG_N_TARG + 1;

   logic                   valid_q;
   logic [PAYLOAD_W-1:0]   payload_q;
   logic [LOG_N_TARG-1:0]  rr_q;

   logic                   load_en;
   logic                   found;
   logic                   grant;
   logic [LOG_N_TARG-1:0]  win;
   logic [LOG_N_TARG-1:0]  next_rr;
   logic [N_TARG_PORT-1:0] win_oh;
   logic [LW-1:0]          cand;

   // The slot can accept a new AW when it is empty or being drained, and the ID FIFO has room
   assign load_en = bus.grant_FIFO_ID_i & (~valid_q | bus.awready_i);

   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int i = 0; i < N_TARG_PORT; i++) begin
         cand = {1'b0, rr_q} + LW'(i);
         if (cand >= LW'(N_TARG_PORT)) cand = cand - LW'(N_TARG_PORT);
         if (!found && bus.awvalid_i[cand[LOG_N_TARG-1:0]]) begin
            found = 1'b1;
            win   = cand[LOG_N_TARG-1:0];
         end
      end
   end

   assign grant   = load_en & found;
   assign win_oh  = N_TARG_PORT'(1) << win;
   assign next_rr = (win == LOG_N_TARG'(N_TARG_PORT - 1)) ? '0 : win + LOG_N_TARG'(1);

   assign bus.awready_o   = grant ? win_oh : '0;
   assign bus.push_ID_o   = grant;
   assign bus.ID_o        = grant ? {win, win_oh} : '0;
   assign bus.awvalid_o   = valid_q;
   assign bus.awpayload_o = payload_q;

   // Output slot: a grant overwrites it (no bubble on drain+grant), otherwise a drain empties it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         payload_q <= '0;
         rr_q      <= '0;
      end else if (grant) begin
         valid_q   <= 1'b1;
         payload_q <= bus.awpayload_i[win];
         rr_q      <= next_rr;
      end else if (bus.awready_i && valid_q) begin
         valid_q   <= 1'b0;
      end
   end
endmodule
